// File: rtl/sequencer_pkg.sv
// ============================================================================
// Module      : sequencer_pkg
// Description : Opcode encodings, FSM state encodings and widths for the
//               processor control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sequencer_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_XOR   = 3'b100,
        OP_BNE   = 3'b101,
        OP_JMP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sequencer.sv
// ============================================================================
// Module      : sequencer
// Description : Fetch/decode/execute control FSM with memory wait-state
//               handshake and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequencer
    import sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [OP_W-1:0]  op,
    input  logic             z_flag,
    input  logic             mem_ready,
    output logic             load_REG,
    output logic             ALU_REG,
    output logic             ALU_add,
    output logic             ALU_sub,
    output logic             ALU_xor,
    output logic             load_IR,
    output logic             incr_PC,
    output logic             load_PC,
    output logic             addr_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    opcode_t          w_op;
    logic             w_retire;
    logic [CNT_W-1:0] r_instr_count;

    assign w_op = opcode_t'(op);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET:  w_next_state = S_FETCH;
            S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_STORE:        w_next_state = S_WRITE;
                    OP_BNE, OP_JMP:  w_next_state = S_BRANCH;
                    OP_HALT:         w_next_state = S_HALT;
                    default:         w_next_state = S_READ;
                endcase
            end
            S_READ:   if (mem_ready) w_next_state = S_FETCH;
            S_WRITE:  if (mem_ready) w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_RESET;
        endcase
    end

    always_comb begin
        load_REG = 1'b0;
        ALU_REG  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        ALU_xor  = 1'b0;
        load_IR  = 1'b0;
        incr_PC  = 1'b0;
        load_PC  = 1'b0;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_rd  = 1'b1;
                load_IR = mem_ready;
                incr_PC = mem_ready;
            end
            S_READ: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    load_REG = 1'b1;
                    case (w_op)
                        OP_ADD: begin ALU_REG = 1'b1; ALU_add = 1'b1; end
                        OP_SUB: begin ALU_REG = 1'b1; ALU_sub = 1'b1; end
                        OP_XOR: begin ALU_REG = 1'b1; ALU_xor = 1'b1; end
                        default: ALU_REG = 1'b0;
                    endcase
                end
            end
            S_WRITE: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
            end
            S_BRANCH: begin
                case (w_op)
                    OP_JMP:  load_PC = 1'b1;
                    OP_BNE:  load_PC = ~z_flag;
                    default: load_PC = 1'b0;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    // HALT retires on the decode cycle that enters S_HALT, never while parked there
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_READ, S_WRITE: w_retire = mem_ready;
            S_BRANCH:        w_retire = 1'b1;
            S_DECODE:        w_retire = (w_op == OP_HALT);
            default:         w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + C_CNT_ONE;
        end
    end

    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_sequencer.sv
// ============================================================================
// Module      : tb_sequencer
// Description : Directed vector table plus hand sequences for halt, async
//               reset and counter wrap (counter narrowed to 4 bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequencer;
    import sequencer_pkg::*;

    localparam int CNT_W = 4;

    // Control bundle: {load_REG,ALU_REG,add,sub,xor,load_IR,incr_PC,load_PC,addr_sel,mem_rd,mem_wr,halted}
    localparam logic [11:0] C_NONE   = 12'h000;
    localparam logic [11:0] C_F_WAIT = 12'h004;
    localparam logic [11:0] C_F_RDY  = 12'h064;
    localparam logic [11:0] C_R_WAIT = 12'h00C;
    localparam logic [11:0] C_R_LOAD = 12'h80C;
    localparam logic [11:0] C_R_ADD  = 12'hE0C;
    localparam logic [11:0] C_R_SUB  = 12'hD0C;
    localparam logic [11:0] C_R_XOR  = 12'hC8C;
    localparam logic [11:0] C_WRITE  = 12'h00A;
    localparam logic [11:0] C_BR_LD  = 12'h010;
    localparam logic [11:0] C_HALT   = 12'h001;

    logic             clock = 1'b0;
    logic             n_reset = 1'b0;
    logic [OP_W-1:0]  op = 3'b000;
    logic             z_flag = 1'b0;
    logic             mem_ready = 1'b0;
    logic             load_REG, ALU_REG, ALU_add, ALU_sub, ALU_xor;
    logic             load_IR, incr_PC, load_PC, addr_sel, mem_rd, mem_wr, halted;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_cnt;

    sequencer #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .op          (op),
        .z_flag      (z_flag),
        .mem_ready   (mem_ready),
        .load_REG    (load_REG),
        .ALU_REG     (ALU_REG),
        .ALU_add     (ALU_add),
        .ALU_sub     (ALU_sub),
        .ALU_xor     (ALU_xor),
        .load_IR     (load_IR),
        .incr_PC     (incr_PC),
        .load_PC     (load_PC),
        .addr_sel    (addr_sel),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       op;
        logic             z;
        logic             rdy;
        logic [11:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs [32];

    function automatic logic [11:0] ctrl_now();
        return {load_REG, ALU_REG, ALU_add, ALU_sub, ALU_xor, load_IR,
                incr_PC, load_PC, addr_sel, mem_rd, mem_wr, halted};
    endfunction

    task automatic check(input string name, input logic [11:0] exp_ctrl,
                         input logic [CNT_W-1:0] exp_count);
        checks++;
        if (ctrl_now() !== exp_ctrl || instr_count !== exp_count) begin
            errors++;
            $display("FAIL %s: ctrl=%03h count=%0d, required ctrl=%03h count=%0d",
                     name, ctrl_now(), instr_count, exp_ctrl, exp_count);
        end
    endtask

    // Drive inputs just after the falling edge, check, then move to the next falling edge
    task automatic step(input logic [2:0] o, input logic z, input logic r,
                        input logic [11:0] exp_ctrl, input logic [CNT_W-1:0] exp_count,
                        input string name);
        op = o;
        z_flag = z;
        mem_ready = r;
        #1;
        check(name, exp_ctrl, exp_count);
        @(negedge clock);
    endtask

    task automatic do_load(input string name);
        step(OP_LOAD, 1'b0, 1'b1, C_F_RDY, exp_cnt, name);
        step(OP_LOAD, 1'b0, 1'b1, C_NONE, exp_cnt, name);
        step(OP_LOAD, 1'b0, 1'b1, C_R_LOAD, exp_cnt, name);
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic pulse_reset(input string name);
        #2 n_reset = 1'b0;
        #1 check(name, C_NONE, 4'd0);
        @(negedge clock);
        n_reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,   1'b0, 1'b1, C_NONE,   4'd0};
        vecs[1]  = '{OP_ADD,   1'b0, 1'b1, C_F_RDY,  4'd0};
        vecs[2]  = '{OP_ADD,   1'b0, 1'b1, C_NONE,   4'd0};
        vecs[3]  = '{OP_ADD,   1'b0, 1'b1, C_R_ADD,  4'd0};
        vecs[4]  = '{OP_STORE, 1'b0, 1'b1, C_F_RDY,  4'd1};
        vecs[5]  = '{OP_STORE, 1'b0, 1'b0, C_NONE,   4'd1};
        vecs[6]  = '{OP_STORE, 1'b0, 1'b0, C_WRITE,  4'd1};
        vecs[7]  = '{OP_STORE, 1'b0, 1'b0, C_WRITE,  4'd1};
        vecs[8]  = '{OP_STORE, 1'b0, 1'b1, C_WRITE,  4'd1};
        vecs[9]  = '{OP_BNE,   1'b1, 1'b0, C_F_WAIT, 4'd2};
        vecs[10] = '{OP_BNE,   1'b1, 1'b1, C_F_RDY,  4'd2};
        vecs[11] = '{OP_BNE,   1'b1, 1'b1, C_NONE,   4'd2};
        vecs[12] = '{OP_BNE,   1'b1, 1'b1, C_NONE,   4'd2};
        vecs[13] = '{OP_BNE,   1'b0, 1'b1, C_F_RDY,  4'd3};
        vecs[14] = '{OP_BNE,   1'b0, 1'b1, C_NONE,   4'd3};
        vecs[15] = '{OP_BNE,   1'b0, 1'b1, C_BR_LD,  4'd3};
        vecs[16] = '{OP_LOAD,  1'b0, 1'b1, C_F_RDY,  4'd4};
        vecs[17] = '{OP_LOAD,  1'b0, 1'b1, C_NONE,   4'd4};
        vecs[18] = '{OP_LOAD,  1'b0, 1'b0, C_R_WAIT, 4'd4};
        vecs[19] = '{OP_LOAD,  1'b0, 1'b1, C_R_LOAD, 4'd4};
        vecs[20] = '{OP_SUB,   1'b0, 1'b1, C_F_RDY,  4'd5};
        vecs[21] = '{OP_SUB,   1'b0, 1'b1, C_NONE,   4'd5};
        vecs[22] = '{OP_SUB,   1'b0, 1'b1, C_R_SUB,  4'd5};
        vecs[23] = '{OP_XOR,   1'b0, 1'b1, C_F_RDY,  4'd6};
        vecs[24] = '{OP_XOR,   1'b0, 1'b1, C_NONE,   4'd6};
        vecs[25] = '{OP_XOR,   1'b0, 1'b1, C_R_XOR,  4'd6};
        vecs[26] = '{OP_JMP,   1'b1, 1'b1, C_F_RDY,  4'd7};
        vecs[27] = '{OP_JMP,   1'b1, 1'b1, C_NONE,   4'd7};
        vecs[28] = '{OP_JMP,   1'b1, 1'b1, C_BR_LD,  4'd7};
        vecs[29] = '{OP_HALT,  1'b0, 1'b1, C_F_RDY,  4'd8};
        vecs[30] = '{OP_HALT,  1'b0, 1'b1, C_NONE,   4'd8};
        vecs[31] = '{OP_HALT,  1'b0, 1'b1, C_HALT,   4'd9};

        op = OP_ADD;
        mem_ready = 1'b1;
        #1 check("reset_held", C_NONE, 4'd0);
        repeat (2) @(negedge clock);
        n_reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            step(vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].ctrl, vecs[i].cnt,
                 $sformatf("vec%0d", i));
        end

        // Parked in HALT regardless of inputs; counter frozen
        for (int i = 0; i < 20; i++) begin
            step(3'(i), i[0], i[1], C_HALT, 4'd9, $sformatf("halt_hold%0d", i));
        end

        pulse_reset("halt_reset");
        step(OP_LOAD, 1'b0, 1'b1, C_NONE, 4'd0, "resume_reset_state");
        exp_cnt = '0;
        do_load("resume_load");

        // Walk the counter up to all-ones, then one more retirement wraps it
        while (exp_cnt != 4'hF) do_load("fill");
        step(OP_LOAD, 1'b0, 1'b1, C_F_RDY, 4'hF, "pre_wrap_count");
        step(OP_JMP, 1'b0, 1'b1, C_NONE, 4'hF, "wrap_decode");
        step(OP_JMP, 1'b0, 1'b1, C_BR_LD, 4'hF, "wrap_branch");
        step(OP_LOAD, 1'b0, 1'b1, C_F_RDY, 4'h0, "wrap_to_zero");

        step(OP_LOAD, 1'b0, 1'b1, C_NONE, 4'h0, "mid_read_decode");
        step(OP_LOAD, 1'b0, 1'b0, C_R_WAIT, 4'h0, "mid_read_wait");
        mem_ready = 1'b0;
        pulse_reset("mid_read_reset");
        step(OP_LOAD, 1'b0, 1'b0, C_NONE, 4'h0, "post_reset_idle");
        step(OP_LOAD, 1'b0, 1'b0, C_F_WAIT, 4'h0, "post_reset_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
